// File: rtl/cmos_capture_ctrl.sv
// cmos_capture_ctrl
// -----------------------------------------------------------------------------
// Frame-level capture sequencer between the OV5640 parallel bus and the
// RGB565 packer. After the first enable following reset it discards
// SKIP_FRAMES settling frames. It then aligns to a VSYNC rising edge and passes
// the byte-valid strobe only for whole frames. Every captured frame is checked
// for line length and line count.
//
// Ports
//   pclk, rst_n      camera pixel clock, asynchronous active-low reset
//   vs_i, href_i     camera VSYNC (rising edge = frame boundary) and HREF
//   pdata_i[7:0]     camera data byte
//   cap_en           level, continuous capture request
//   cap_single       one-cycle pulse, capture exactly one frame
//   de_o, pdata_o    gated byte-valid and data to the packer (1 cycle latency)
//   vs_o             vs_i delayed one cycle
//   busy_o           sequencer not idle (registered, lags state by one cycle)
//   frame_start_o    pulse when a captured frame begins
//   frame_done_o     pulse when a captured frame closes
//   frame_err_o      pulse with frame_done_o when the frame failed its checks
//   lines_o[10:0]    line count of the last closed frame
//   frame_cnt_o[15:0] captured-frame counter, wraps
//
// Handshake: there is no back-pressure. de_o qualifies pdata_o in the same
// cycle, and the packer must accept every byte that de_o marks.
module cmos_capture_ctrl #(
  parameter int H_PIX       = 640,
  parameter int V_LINES     = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vs_i,
  input  logic        href_i,
  input  logic [7:0]  pdata_i,
  input  logic        cap_en,
  input  logic        cap_single,
  output logic        de_o,
  output logic [7:0]  pdata_o,
  output logic        vs_o,
  output logic        busy_o,
  output logic        frame_start_o,
  output logic        frame_done_o,
  output logic        frame_err_o,
  output logic [10:0] lines_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [11:0] LINE_BYTES  = 12'(2 * H_PIX);
  localparam logic [10:0] FRAME_LINES = 11'(V_LINES);
  localparam logic [7:0]  SKIP_LAST   = (SKIP_FRAMES > 0) ? 8'(SKIP_FRAMES - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    ARM     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t      state;
  logic        vs_d;
  logic        href_d;
  logic        settled;
  logic        single;
  logic [7:0]  skip_cnt;
  logic [11:0] byte_cnt;
  logic [10:0] line_cnt;
  logic        line_err;

  logic        vs_rise;
  logic        line_end;
  logic [10:0] line_cnt_fin;
  logic        line_err_fin;

  assign vs_rise  = vs_i & ~vs_d;
  assign line_end = href_d & ~href_i;

  // Line counters as they stand after this cycle's line_end, if any. Used both
  // for normal counting and for the close checks, so a line that ends in the
  // same cycle as the VSYNC rise is included in the frame it belongs to.
  always_comb begin
    line_cnt_fin = line_cnt;
    line_err_fin = line_err;
    if (line_end) begin
      if (line_cnt != 11'h7FF) line_cnt_fin = line_cnt + 11'd1;
      if (byte_cnt != LINE_BYTES) line_err_fin = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vs_d          <= 1'b0;
      href_d        <= 1'b0;
      settled       <= 1'b0;
      single        <= 1'b0;
      skip_cnt      <= 8'd0;
      byte_cnt      <= 12'd0;
      line_cnt      <= 11'd0;
      line_err      <= 1'b0;
      de_o          <= 1'b0;
      pdata_o       <= 8'd0;
      vs_o          <= 1'b0;
      busy_o        <= 1'b0;
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      lines_o       <= 11'd0;
      frame_cnt_o   <= 16'd0;
    end else begin
      vs_d          <= vs_i;
      href_d        <= href_i;
      pdata_o       <= pdata_i;
      vs_o          <= vs_i;
      de_o          <= href_i & ~vs_i & (state == CAPTURE) & ~vs_rise;
      busy_o        <= (state != IDLE);
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_err_o   <= 1'b0;

      case (state)
        IDLE: begin
          if (cap_en | cap_single) begin
            single   <= cap_single & ~cap_en;
            skip_cnt <= 8'd0;
            state    <= settled ? ARM : SKIP;
          end
        end

        SKIP: begin
          if (!cap_en && !single) begin
            state <= IDLE;
          end else if (SKIP_FRAMES == 0) begin
            settled <= 1'b1;
            state   <= ARM;
          end else if (vs_rise) begin
            if (skip_cnt == SKIP_LAST) begin
              settled <= 1'b1;
              state   <= ARM;
            end else begin
              skip_cnt <= skip_cnt + 8'd1;
            end
          end
        end

        ARM: begin
          byte_cnt <= 12'd0;
          line_cnt <= 11'd0;
          line_err <= 1'b0;
          if (!cap_en && !single) begin
            state <= IDLE;
          end else if (vs_rise) begin
            state         <= CAPTURE;
            frame_start_o <= 1'b1;
          end
        end

        CAPTURE: begin
          if (vs_rise) begin
            lines_o      <= line_cnt_fin;
            frame_cnt_o  <= frame_cnt_o + 16'd1;
            frame_done_o <= 1'b1;
            frame_err_o  <= line_err_fin | (line_cnt_fin != FRAME_LINES);
            byte_cnt     <= 12'd0;
            line_cnt     <= 11'd0;
            line_err     <= 1'b0;
            // A dropped cap_en only takes effect here, so the frame in
            // flight always completes.
            if (!single && cap_en) frame_start_o <= 1'b1;
            else                   state         <= IDLE;
          end else if (line_end) begin
            line_cnt <= line_cnt_fin;
            line_err <= line_err_fin;
            byte_cnt <= 12'd0;
          end else if (href_i && byte_cnt != 12'hFFF) begin
            byte_cnt <= byte_cnt + 12'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
